// File: rtl/load_store_unit.sv
// load_store_unit
//   Sits in front of a word-indexed data memory. Accepts byte-addressed CPU
//   load/store requests over valid/ready, drives the memory's addr/din/we/re
//   ports and returns sign/zero-extended load data. Byte and half stores use
//   read-modify-write. Misaligned, out-of-range or illegal-width accesses are
//   answered with resp_err and never touch memory.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_addr/we/funct3/wdata  byte address, store flag, RV32I width, store data
//   resp_valid/resp_ready     response handshake (held until accepted)
//   resp_rdata/resp_err       extended load data (0 for stores/errors), error
//   mem_addr/din/we/re        word index, write data and strobes to memory
//   mem_rdata                 combinational read data from memory
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// READ  | mem_re=1; load data or RMW base word captured at end of cycle
// WRITE | mem_we=1; word (or merged word) commits on the edge leaving WRITE
// RESP  | resp_valid=1 until resp_ready
module load_store_unit #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  state_t      state;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;
  logic        store_q;

  logic        acc_err;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  assign req_ready = (state == IDLE);
  assign mem_re    = (state == READ);
  // A WRITE cycle that coincides with reset must not commit.
  assign mem_we    = (state == WRITE) && !rst;

  always_comb begin
    acc_err = 1'b0;
    case (req_funct3)
      3'b000:  acc_err = 1'b0;
      3'b001:  acc_err = req_addr[0];
      3'b010:  acc_err = |req_addr[1:0];
      3'b100:  acc_err = req_we;
      3'b101:  acc_err = req_we | req_addr[0];
      default: acc_err = 1'b1;
    endcase
    if (req_addr[31:2] >= DEPTH_W) acc_err = 1'b1;
  end

  // Lane extraction: shifting by the byte offset puts the addressed lane at
  // bit 0 for both bytes and (aligned) halves.
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    lane_mask = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << {off_q, 3'b000};
    merged    = (mem_rdata & ~lane_mask) | ((wdata_q << {off_q, 3'b000}) & lane_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      mem_addr   <= 32'd0;
      mem_din    <= 32'd0;
      off_q      <= 2'd0;
      f3_q       <= 3'd0;
      wdata_q    <= 32'd0;
      store_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            off_q   <= req_addr[1:0];
            f3_q    <= req_funct3;
            wdata_q <= req_wdata;
            store_q <= req_we;
            if (acc_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              mem_addr <= {2'b00, req_addr[31:2]};
              if (req_we && req_funct3 == 3'b010) begin
                mem_din <= req_wdata;
                state   <= WRITE;
              end else begin
                state <= READ;
              end
            end
          end
        end
        READ: begin
          if (store_q) begin
            mem_din <= merged;
            state   <= WRITE;
          end else begin
            resp_rdata <= load_data;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WRITE: begin
          resp_rdata <= 32'd0;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
